instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Consumer of the program counter's 8-bit `address`. Producer of its `jump`/`jump_adr`/`branch`/`branch_adr` controls.
- Fetches 16-bit instructions from instruction memory over a req/ready handshake and presents them downstream on a valid/ready handshake.
- Resolves JMP/BEQ redirects back to the PC.
- Holds the PC while stalled by issuing a self-jump (`jump=1`, `jump_adr` = current address). The PC has no enable, so this is the only way to stop it.

Parameters:
- ADDR_W, 8, address width; must match PC width.
- INSTR_W, 16, instruction width.
- TIMEOUT_CYCLES, 15, max REQ-state cycles; used only with FETCH_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- pc_address  in  ADDR_W  current PC address.
- jump  out  1  PC jump/hold control.
- jump_adr  out  ADDR_W  jump target, or hold address.
- branch  out  1  PC branch control.
- branch_adr  out  ADDR_W  branch target.
- mem_req  out  1  instruction memory read request.
- mem_addr  out  ADDR_W  memory read address.
- mem_ready  in  1  memory data valid, sampled only while mem_req=1.
- mem_rdata  in  INSTR_W  memory read data.
- zero_flag  in  1  ALU zero flag for BEQ.
- instr_valid  out  1  instruction available downstream.
- instr  out  INSTR_W  instruction register.
- instr_ready  in  1  downstream accept.
- fetch_fault  out  1  sticky timeout flag; tied 0 without the macro.

Behaviour:
- Instruction format:
  - [15:12] opcode; [11:8] don't-care to this block; [7:0] target.
  - OPC_JMP = 4'hE; OPC_BEQ = 4'hF.
- States: IDLE, REQ, ISSUE (plus HALT with the macro).
- IDLE:
  - Entered on reset. Lasts exactly 1 cycle, then REQ.
  - Outputs: jump=1, jump_adr=pc_address (hold); mem_req=0; instr_valid=0.
- REQ:
  - mem_req=1, mem_addr=pc_address (combinational).
  - Hold PC: jump=1, jump_adr=pc_address.
  - On mem_ready=1: capture mem_rdata into instr; go to ISSUE.
  - Zero-wait memory (ready in the first REQ cycle) is legal.
- ISSUE:
  - instr_valid=1; instr stable; mem_req=0.
  - While instr_ready=0: hold PC via self-jump.
  - Handshake cycle (instr_valid & instr_ready), resolved combinationally:
    - opcode==OPC_JMP: jump=1, jump_adr=instr[7:0], branch=0.
    - Else opcode==OPC_BEQ and zero_flag=1: jump=0, branch=1, branch_adr=instr[7:0].
    - Otherwise: jump=0, branch=0, so the PC increments.
  - Next state after the handshake is REQ. The PC's new value is visible there.
- Priority: jump wins over branch, matching PC priority. Never assert both.
- branch_adr = instr[7:0] whenever branch=0 (don't-care value, kept deterministic).
- Minimum throughput: one instruction per 2 cycles.
- Fetch latency: pc_address to instr_valid = 1 cycle + memory wait states.
- mem_ready outside REQ is ignored.
- Address wrap 0xFF→0x00 is handled by the PC; no special case here.
- Reset values: state=IDLE, instr=0, instr_valid=0, mem_req=0, branch=0, jump=1, jump_adr=pc_address, fetch_fault=0.
- Reset mid-operation:
  - Asynchronous: instr_valid and mem_req drop immediately.
  - A pending memory transaction is abandoned.
  - A late mem_ready after reset release is ignored (block is in IDLE).

Optional Feature:
- FETCH_TIMEOUT_EN defined:
  - A 4-bit counter counts consecutive REQ cycles and clears on entry to REQ.
  - If mem_ready is still absent after TIMEOUT_CYCLES cycles: set fetch_fault=1 (sticky until reset) and go to HALT.
  - HALT: mem_req=0, instr_valid=0, PC held by self-jump forever.
- FETCH_TIMEOUT_EN undefined: no counter, no HALT state, fetch_fault constant 0. REQ waits indefinitely.

Decomposition:
- fetch_pkg holds:
  - State enum.
  - OPC_JMP, OPC_BEQ.
  - Opcode/target field positions (OPC_MSB, OPC_LSB, TGT_MSB, TGT_LSB).
  - Default widths.
- One sub-module, instr_redirect_decode (combinational):
  - Inputs: instr, zero_flag, handshake, pc_address.
  - Outputs: jump, jump_adr, branch, branch_adr.
  - Keeps the redirect logic separate from the FSM.

Test Plan:
- Reset and first fetch: reset low 3 cycles, release, mem_ready=1 on first REQ cycle, mem_rdata=16'h1234 → mem_addr=0x00; next cycle instr_valid=1, instr=16'h1234; handshake with jump=0, branch=0; next mem_addr=0x01.
- Wait states: mem_ready delayed 3 cycles → mem_req and mem_addr=0x05 stable, jump=1, jump_adr=0x05 every cycle, pc_address unchanged.
- JMP: mem_rdata=16'hE040, handshake → jump=1, jump_adr=0x40, branch=0; next REQ mem_addr=0x40.
- BEQ: 16'hF020 at PC 0x10:
  - zero_flag=1 → branch=1, branch_adr=0x20; next mem_addr=0x20.
  - zero_flag=0 → next mem_addr=0x11.
- Backpressure and reset: instr_ready low 4 cycles → instr_valid=1, instr stable, mem_req=0, PC held. Assert reset mid-ISSUE → instr_valid=0 immediately, state IDLE.
- Timeout (macro on): mem_ready never asserted → fetch_fault=1 after 15 REQ cycles, mem_req=0, PC held until reset.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared constants, state encoding and field positions for the
//            instruction fetch unit and its redirect decoder.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int ADDR_W_DEF         = 8;
  localparam int INSTR_W_DEF        = 16;
  localparam int TIMEOUT_CYCLES_DEF = 15;

  // Instruction field layout: [15:12] opcode, [11:8] unused here, [7:0] target
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int TGT_MSB = 7;
  localparam int TGT_LSB = 0;

  localparam logic [3:0] OPC_JMP = 4'hE;
  localparam logic [3:0] OPC_BEQ = 4'hF;

  typedef logic [1:0] state_t;

  localparam state_t c_st_idle  = 2'd0;
  localparam state_t c_st_req   = 2'd1;
  localparam state_t c_st_issue = 2'd2;
  localparam state_t c_st_halt  = 2'd3;

  function automatic logic [OPC_MSB-OPC_LSB:0] get_opcode(
    input logic [INSTR_W_DEF-1:0] word
  );
    return word[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [TGT_MSB-TGT_LSB:0] get_target(
    input logic [INSTR_W_DEF-1:0] word
  );
    return word[TGT_MSB:TGT_LSB];
  endfunction

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/instr_redirect_decode.sv
`default_nettype none
// ============================================================================
// Module   : instr_redirect_decode
// Brief    : Combinational PC control: self-jump hold outside the handshake,
//            JMP / taken-BEQ / sequential resolution on the handshake cycle.
// Revision : 1.0 - initial release
// ============================================================================
module instr_redirect_decode
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic [INSTR_W-1:0] instr,
  input  logic               zero_flag,
  input  logic               handshake,
  input  logic [ADDR_W-1:0]  pc_address,
  output logic               jump,
  output logic [ADDR_W-1:0]  jump_adr,
  output logic               branch,
  output logic [ADDR_W-1:0]  branch_adr
);

  logic [OPC_MSB-OPC_LSB:0] w_opcode;
  logic [ADDR_W-1:0]        w_target;
  logic                     w_unused;

  assign w_opcode = get_opcode(INSTR_W_DEF'(instr));
  assign w_target = ADDR_W'(get_target(INSTR_W_DEF'(instr)));
  assign w_unused = ^instr[OPC_LSB-1:TGT_MSB+1];

  // Jump is checked first so jump and branch can never be raised together.
  always_comb begin
    jump       = 1'b1;
    jump_adr   = pc_address;
    branch     = 1'b0;
    branch_adr = w_target;
    if (handshake) begin
      if (w_opcode == OPC_JMP) begin
        jump_adr = w_target;
      end else if ((w_opcode == OPC_BEQ) && zero_flag) begin
        jump   = 1'b0;
        branch = 1'b1;
      end else begin
        jump = 1'b0;
      end
    end
  end

endmodule : instr_redirect_decode
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : Fetches instructions over req/ready, issues them over valid/ready
//            and steers the PC. Optional macro: FETCH_TIMEOUT_EN (REQ timeout
//            with sticky fetch_fault and HALT state).
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int INSTR_W        = INSTR_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_address,
  output logic               jump,
  output logic [ADDR_W-1:0]  jump_adr,
  output logic               branch,
  output logic [ADDR_W-1:0]  branch_adr,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ready,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               zero_flag,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  input  logic               instr_ready,
  output logic               fetch_fault
);

  state_t             r_state;
  state_t             w_state_next;
  logic [INSTR_W-1:0] r_instr;
  logic               w_handshake;
  logic               w_capture;
  logic               w_timeout;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [3:0] c_cnt_last = 4'(TIMEOUT_CYCLES - 1);

  logic [3:0] r_cnt;
  logic       r_fault;

  assign w_timeout = (r_state == c_st_req) && !mem_ready && (r_cnt == c_cnt_last);

  // Held at zero outside REQ so every REQ visit starts counting from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= 4'd0;
    end else if (r_state != c_st_req) begin
      r_cnt <= 4'd0;
    end else if (!mem_ready) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fault <= 1'b0;
    end else if (w_timeout) begin
      r_fault <= 1'b1;
    end
  end

  assign fetch_fault = r_fault;
`else
  localparam int c_unused_timeout = TIMEOUT_CYCLES;

  assign w_timeout   = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  assign w_capture   = (r_state == c_st_req) && mem_ready;
  assign instr_valid = (r_state == c_st_issue);
  assign w_handshake = instr_valid && instr_ready;
  assign mem_req     = (r_state == c_st_req);
  assign mem_addr    = pc_address;
  assign instr       = r_instr;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle:  w_state_next = c_st_req;
      c_st_req: begin
        if (mem_ready) begin
          w_state_next = c_st_issue;
        end else if (w_timeout) begin
          w_state_next = c_st_halt;
        end
      end
      c_st_issue: begin
        if (instr_ready) begin
          w_state_next = c_st_req;
        end
      end
`ifdef FETCH_TIMEOUT_EN
      c_st_halt:  w_state_next = c_st_halt;
`endif
      default:    w_state_next = c_st_idle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr <= '0;
    end else if (w_capture) begin
      r_instr <= mem_rdata;
    end
  end

  instr_redirect_decode #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_redirect (
    .instr      (r_instr),
    .zero_flag  (zero_flag),
    .handshake  (w_handshake),
    .pc_address (pc_address),
    .jump       (jump),
    .jump_adr   (jump_adr),
    .branch     (branch),
    .branch_adr (branch_adr)
  );

endmodule : instr_fetch_unit
`default_nettype wire
